int2float_pipe: RTL and testbench

INT2FLOAT_PIPE -- requirements
Module: int2float_pipe

---
 rtl/int2float_pipe_pkg.sv | 12 +
 rtl/int2float_pipe_lod.sv | 20 ++
 rtl/int2float_pipe.sv | 152 +++++++++++++++
 tb/tb_int2float_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int2float_pipe_pkg.sv
// Shared constants and helpers for the integer-to-float pipeline.
package int2float_pipe_pkg;

   localparam logic RND_TRUNC = 1'b0;
   localparam logic RND_RNE   = 1'b1;

   // Smallest exponent width able to hold the largest exponent W-MW.
   function automatic int unsigned min_ew(input int unsigned w, input int unsigned mw);
      return $clog2(w - mw + 1);
   endfunction

endpackage

// File: rtl/int2float_pipe_lod.sv
// Leading-one detector: priority encoder reporting the highest set bit and an all-zero flag.
module int2float_pipe_lod #(
   parameter int unsigned W  = 11,
   parameter int unsigned PW = 4
) (
   input  logic [W-1:0]  data,
   output logic [PW-1:0] pos,
   output logic          zero
);

   always_comb begin
      pos = '0;
      for (int i = 0; i < int'(W); i++) begin
         if (data[i]) pos = PW'(i);
      end
   end

   assign zero = (data == '0);

endmodule

// File: rtl/int2float_pipe.sv
// Two-stage integer to small-float converter with truncate/RNE rounding and saturation.
module int2float_pipe
   import int2float_pipe_pkg::*;
#(
   parameter int unsigned W      = 11,
   parameter int unsigned MW     = 4,
   parameter int unsigned EW     = 3,
   parameter bit          SIGNED = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic          in_rnd,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_sign,
   output logic [EW-1:0] out_exp,
   output logic [MW-1:0] out_man,
   output logic          out_inexact,
   output logic          out_ovf,
   output logic [15:0]   conv_cnt
);

   localparam int unsigned PW   = $clog2(W);
   localparam int unsigned XW   = PW + 1;
   localparam int unsigned EMAX = W - MW;
   localparam logic [MW-1:0] MAN_CARRY = MW'(1) << (MW - 1);

   if (W <= MW) begin : g_bad_w
      $error("int2float_pipe: W (%0d) must exceed MW (%0d)", W, MW);
   end
   if (EW < min_ew(W, MW)) begin : g_bad_ew
      $error("int2float_pipe: EW (%0d) too small for W-MW (%0d)", EW, W - MW);
   end

   logic          s1_valid;
   logic [W-1:0]  s1_mag;
   logic [PW-1:0] s1_pos;
   logic          s1_zero;
   logic          s1_sign;
   logic          s1_rnd;

   logic          adv1;
   logic          adv2;

   assign adv2     = !out_valid || out_ready;
   assign adv1     = !s1_valid || adv2;
   assign in_ready = adv1;

   // Stage 1: magnitude and leading-one position.
   logic          neg_c;
   logic [W-1:0]  mag_c;
   logic [PW-1:0] pos_c;
   logic          zero_c;

   assign neg_c = SIGNED && in_data[W-1];
   assign mag_c = neg_c ? (~in_data + W'(1)) : in_data;

   int2float_pipe_lod #(.W(W), .PW(PW)) lod (
      .data (mag_c),
      .pos  (pos_c),
      .zero (zero_c)
   );

   // Stage 2: align, round and saturate.
   logic [PW-1:0] sh;
   logic [MW-1:0] top;
   logic [W-1:0]  rem;
   logic [W-1:0]  half;
   logic          rnd_up;
   logic [MW:0]   man_r;
   logic [XW-1:0] exp_r;
   logic [EW-1:0] exp_c;
   logic [MW-1:0] man_c;
   logic          inx_c;
   logic          ovf_c;

   always_comb begin
      sh     = '0;
      top    = '0;
      rem    = '0;
      half   = '0;
      rnd_up = 1'b0;
      man_r  = '0;
      exp_r  = '0;
      exp_c  = '0;
      man_c  = s1_mag[MW-1:0];
      inx_c  = 1'b0;
      ovf_c  = 1'b0;
      if (!s1_zero && (s1_pos >= PW'(MW))) begin
         sh     = s1_pos - PW'(MW - 1);
         top    = MW'(s1_mag >> sh);
         rem    = s1_mag & ((W'(1) << sh) - W'(1));
         half   = W'(1) << (sh - PW'(1));
         inx_c  = (rem != '0);
         rnd_up = (s1_rnd == RND_RNE) && ((rem > half) || ((rem == half) && top[0]));
         man_r  = {1'b0, top} + (MW + 1)'(rnd_up);
         exp_r  = XW'(sh) + XW'(man_r[MW]);
         man_c  = man_r[MW] ? MAN_CARRY : man_r[MW-1:0];
         exp_c  = EW'(exp_r);
         if (exp_r > XW'(EMAX)) begin
            exp_c = EW'(EMAX);
            man_c = '1;
            ovf_c = 1'b1;
            inx_c = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s1_mag      <= '0;
         s1_pos      <= '0;
         s1_zero     <= 1'b0;
         s1_sign     <= 1'b0;
         s1_rnd      <= 1'b0;
         out_valid   <= 1'b0;
         out_sign    <= 1'b0;
         out_exp     <= '0;
         out_man     <= '0;
         out_inexact <= 1'b0;
         out_ovf     <= 1'b0;
         conv_cnt    <= '0;
      end else begin
         if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_mag  <= mag_c;
               s1_pos  <= pos_c;
               s1_zero <= zero_c;
               s1_sign <= neg_c;
               s1_rnd  <= in_rnd;
            end
         end
         if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_sign    <= s1_sign;
               out_exp     <= exp_c;
               out_man     <= man_c;
               out_inexact <= inx_c;
               out_ovf     <= ovf_c;
            end
         end
         if (out_valid && out_ready) conv_cnt <= conv_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_int2float_pipe.sv
// Randomised scoreboard bench for int2float_pipe, unsigned and signed instances side by side.
module tb_int2float_pipe;

   localparam int unsigned W  = 11;
   localparam int unsigned MW = 4;
   localparam int unsigned EW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          in_rnd = 1'b0;
   logic          out_ready = 1'b0;

   logic          u_in_ready, u_out_valid, u_sign, u_inexact, u_ovf;
   logic [EW-1:0] u_exp;
   logic [MW-1:0] u_man;
   logic [15:0]   u_cnt;
   logic          s_in_ready, s_out_valid, s_sign, s_inexact, s_ovf;
   logic [EW-1:0] s_exp;
   logic [MW-1:0] s_man;
   logic [15:0]   s_cnt;

   int2float_pipe #(.W(W), .MW(MW), .EW(EW), .SIGNED(1'b0)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready),
      .in_data(in_data), .in_rnd(in_rnd), .out_valid(u_out_valid), .out_ready(out_ready),
      .out_sign(u_sign), .out_exp(u_exp), .out_man(u_man), .out_inexact(u_inexact),
      .out_ovf(u_ovf), .conv_cnt(u_cnt)
   );

   int2float_pipe #(.W(W), .MW(MW), .EW(EW), .SIGNED(1'b1)) s_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_data(in_data), .in_rnd(in_rnd), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_sign(s_sign), .out_exp(s_exp), .out_man(s_man), .out_inexact(s_inexact),
      .out_ovf(s_ovf), .conv_cnt(s_cnt)
   );

   always #5 clk = ~clk;

   logic [9:0] act_u, act_s;
   assign act_u = {u_sign, u_exp, u_man, u_inexact, u_ovf};
   assign act_s = {s_sign, s_exp, s_man, s_inexact, s_ovf};

   int n_chk  = 0;
   int n_pass = 0;
   int acc_cnt = 0;
   logic [9:0] q_u[$];
   logic [9:0] q_s[$];
   logic [9:0] prev_u = '0, prev_s = '0;
   logic       stall_u = 1'b0, stall_s = 1'b0;

   typedef struct {
      logic [10:0] d;
      logic        r;
      bit          sg;
      logic [9:0]  e;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   function automatic logic [9:0] pk(input bit s, input int e, input int m, input bit i, input bit o);
      return {s, 3'(e), 4'(m), i, o};
   endfunction

   // Reference conversion from the number-format rules, using plain integers.
   function automatic logic [9:0] ref_conv(input logic [10:0] d, input logic rnd, input bit sgn);
      int v, p, e, m, rem, half;
      bit s, inx, ovf;
      s   = sgn && d[10];
      v   = s ? 2048 - int'(d) : int'(d);
      inx = 1'b0;
      ovf = 1'b0;
      if (v < 16) begin
         e = 0;
         m = v;
      end else begin
         p = 0;
         while ((v >> (p + 1)) != 0) p++;
         e    = p - 3;
         m    = v >> e;
         rem  = v - (m << e);
         half = 1 << (e - 1);
         inx  = (rem != 0);
         if (rnd && ((rem > half) || ((rem == half) && (m % 2 == 1)))) m++;
         if (m == 16) begin
            m = 8;
            e++;
         end
         if (e > 7) begin
            e = 7; m = 15; ovf = 1'b1; inx = 1'b1;
         end
      end
      return pk(s, e, m, inx, ovf);
   endfunction

   function automatic void add_vec(input logic [10:0] d, input logic r, input bit sg, input logic [9:0] e);
      vec_t v;
      v.d = d; v.r = r; v.sg = sg; v.e = e;
      vecs.push_back(v);
   endfunction

   function automatic logic [10:0] rand_word();
      case ($urandom % 4)
         0:       return 11'($urandom_range(0, 2047));
         1:       return 11'($urandom_range(0, 31));
         2:       return 11'($urandom_range(1900, 2047));
         default: return 11'(($urandom_range(8, 15) * 2 + 1) << $urandom_range(0, 6));
      endcase
   endfunction

   // Scoreboard, stall-stability and acceptance tracking on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (stall_u) begin
            chk("hold_u_valid", 32'(u_out_valid), 32'd1);
            chk("hold_u_data", 32'(act_u), 32'(prev_u));
         end
         if (stall_s) begin
            chk("hold_s_valid", 32'(s_out_valid), 32'd1);
            chk("hold_s_data", 32'(act_s), 32'(prev_s));
         end
         if (u_out_valid && out_ready) begin
            if (q_u.size() == 0) fail_now("u_unexpected_result");
            else chk("u_result", 32'(act_u), 32'(q_u.pop_front()));
         end
         if (s_out_valid && out_ready) begin
            if (q_s.size() == 0) fail_now("s_unexpected_result");
            else chk("s_result", 32'(act_s), 32'(q_s.pop_front()));
         end
         stall_u = u_out_valid && !out_ready;
         stall_s = s_out_valid && !out_ready;
         prev_u  = act_u;
         prev_s  = act_s;
         if (in_valid && u_in_ready) begin
            q_u.push_back(ref_conv(in_data, in_rnd, 1'b0));
            acc_cnt++;
         end
         if (in_valid && s_in_ready) q_s.push_back(ref_conv(in_data, in_rnd, 1'b1));
      end else begin
         stall_u = 1'b0;
         stall_s = 1'b0;
      end
   end

   task automatic send(input logic [10:0] d, input logic r);
      int start;
      bit done;
      start    = acc_cnt;
      done     = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_rnd   = r;
      for (int i = 0; i < 50 && !done; i++) begin
         @(posedge clk); #1;
         if (acc_cnt != start) done = 1'b1;
      end
      in_valid = 1'b0;
      if (!done) fail_now("send_timeout");
   endtask

   task automatic drain();
      bit done;
      done      = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(posedge clk); #1;
         if (q_u.size() == 0 && q_s.size() == 0) done = 1'b1;
      end
      if (!done) fail_now("drain_timeout");
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      q_u.delete();
      q_s.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_u_in_ready", 32'(u_in_ready), 32'd1);
      chk("rst_s_in_ready", 32'(s_in_ready), 32'd1);
      chk("rst_u_out_valid", 32'(u_out_valid), 32'd0);
      chk("rst_u_data", 32'(act_u), 32'd0);
      chk("rst_s_data", 32'(act_s), 32'd0);
      chk("rst_u_cnt", 32'(u_cnt), 32'd0);
      chk("rst_s_cnt", 32'(s_cnt), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc_base, target, guard;

      add_vec(11'd5,    1'b0, 1'b0, pk(0, 0, 5, 0, 0));
      add_vec(11'd0,    1'b1, 1'b0, pk(0, 0, 0, 0, 0));
      add_vec(11'd1023, 1'b0, 1'b0, pk(0, 6, 15, 1, 0));
      add_vec(11'd1023, 1'b1, 1'b0, pk(0, 7, 8, 1, 0));
      add_vec(11'd2047, 1'b1, 1'b0, pk(0, 7, 15, 1, 1));
      add_vec(11'd2047, 1'b0, 1'b0, pk(0, 7, 15, 1, 0));
      add_vec(11'd25,   1'b1, 1'b0, pk(0, 1, 12, 1, 0));
      add_vec(11'd27,   1'b1, 1'b0, pk(0, 1, 14, 1, 0));
      add_vec(11'd24,   1'b1, 1'b0, pk(0, 1, 12, 0, 0));
      add_vec(11'd2043, 1'b0, 1'b1, pk(1, 0, 5, 0, 0));
      add_vec(11'd1024, 1'b0, 1'b1, pk(1, 7, 8, 0, 0));
      add_vec(11'd2047, 1'b1, 1'b1, pk(1, 0, 1, 0, 0));

      repeat (3) @(posedge clk);
      #1;
      do_reset();

      foreach (vecs[i]) chk("model_pin", 32'(ref_conv(vecs[i].d, vecs[i].r, vecs[i].sg)), 32'(vecs[i].e));

      // Two-cycle latency on an empty pipeline.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 11'd5;
      in_rnd    = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("latency_cycle1_valid", 32'(u_out_valid), 32'd0);
      @(negedge clk);
      chk("latency_cycle2_valid", 32'(u_out_valid), 32'd1);
      chk("latency_cycle2_data", 32'(act_u), 32'(pk(0, 0, 5, 0, 0)));
      @(posedge clk); #1;

      foreach (vecs[i]) send(vecs[i].d, vecs[i].r);
      drain();

      // Back-to-back burst: no bubbles in either direction.
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_data  = rand_word();
         in_rnd   = 1'($urandom);
         @(negedge clk);
         chk("burst_in_ready", 32'(u_in_ready), 32'd1);
         if (i >= 2) chk("burst_out_valid", 32'(u_out_valid), 32'd1);
         @(posedge clk); #1;
      end
      drain();

      // Twenty-word stream with random backpressure from a clean count.
      do_reset();
      target = acc_cnt + 20;
      guard  = 0;
      while (acc_cnt < target && guard < 2000) begin
         in_valid  = ($urandom % 4) != 0;
         in_data   = rand_word();
         in_rnd    = 1'($urandom);
         out_ready = 1'($urandom);
         @(posedge clk); #1;
         guard++;
      end
      if (acc_cnt < target) fail_now("stream_timeout");
      in_valid = 1'b0;
      drain();
      chk("stream_u_cnt", 32'(u_cnt), 32'd20);
      chk("stream_s_cnt", 32'(s_cnt), 32'd20);

      // Fill both stages, then reset: nothing in flight may emerge.
      out_ready = 1'b0;
      send(11'd1000, 1'b1);
      send(11'd77, 1'b0);
      @(negedge clk);
      chk("full_in_ready", 32'(u_in_ready), 32'd0);
      chk("full_out_valid", 32'(u_out_valid), 32'd1);
      @(posedge clk); #1;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_idle", 32'(u_out_valid), 32'd0);
         chk("post_rst_idle_s", 32'(s_out_valid), 32'd0);
      end
      chk("post_rst_cnt", 32'(u_cnt), 32'd0);
      @(posedge clk); #1;
      send(11'd27, 1'b1);
      drain();
      chk("post_rst_one_cnt", 32'(u_cnt), 32'd1);

      // Long random run with mixed backpressure and rounding modes.
      acc_base = acc_cnt - 1;
      target   = acc_cnt + 300;
      guard    = 0;
      while (acc_cnt < target && guard < 5000) begin
         in_valid  = ($urandom % 5) != 0;
         in_data   = rand_word();
         in_rnd    = 1'($urandom);
         out_ready = ($urandom % 3) != 0;
         @(posedge clk); #1;
         guard++;
      end
      if (acc_cnt < target) fail_now("random_timeout");
      in_valid = 1'b0;
      drain();
      chk("random_u_cnt", 32'(u_cnt), 32'(acc_cnt - acc_base));
      chk("random_s_cnt", 32'(s_cnt), 32'(acc_cnt - acc_base));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
